// File: rtl/alu_seq_pkg.sv
// Shared types and widths for the ALU operand sequencer and the downstream ALU.
package alu_seq_pkg;

    localparam int unsigned WIDTH_C    = 7;
    localparam int unsigned OP_WIDTH_C = 2;

    typedef enum logic [1:0] {
        S_LOAD_A  = 2'b00,
        S_LOAD_B  = 2'b01,
        S_LOAD_OP = 2'b10,
        S_RUN     = 2'b11
    } seq_state_t;

endpackage

// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and registered
// rising-edge detector on the debounced level.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_rise
);

    localparam int unsigned        CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_d;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Any agreement restarts the count, so only an unbroken run of disagreement flips the level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (r_sync2 == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
            r_cnt   <= '0;
            r_level <= ~r_level;
        end else begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level_d <= 1'b0;
            r_rise    <= 1'b0;
        end else begin
            r_level_d <= r_level;
            r_rise    <= r_level & ~r_level_d;
        end
    end

    assign btn_level = r_level;
    assign btn_rise  = r_rise;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Single-button operand entry: latches A, B and OpCode in turn, then presents them in RUN.
// Optional feature macro: ALU_SEQ_LIVE_OP_EN (OpCode follows sw_op every cycle while in RUN).
module alu_operand_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH           = WIDTH_C,
    parameter int unsigned OP_WIDTH        = OP_WIDTH_C,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_next,
    input  logic [WIDTH-1:0]    sw_data,
    input  logic [OP_WIDTH-1:0] sw_op,
    output logic [WIDTH-1:0]    A,
    output logic [WIDTH-1:0]    B,
    output logic [OP_WIDTH-1:0] OpCode,
    output logic                operands_valid,
    output logic [1:0]          step,
    output logic                press
);

    logic                w_level;
    logic                w_rise;
    logic                w_press;

    seq_state_t          r_state;
    seq_state_t          w_state_next;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    w_a_next;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    w_b_next;
    logic [OP_WIDTH-1:0] r_op;
    logic [OP_WIDTH-1:0] w_op_next;
    logic                r_valid;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_next),
        .btn_level(w_level),
        .btn_rise (w_rise)
    );

    // A rise is only honoured while the debounced level is still high.
    assign w_press = w_rise & w_level;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_LOAD_A;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_a     <= w_a_next;
            r_b     <= w_b_next;
            r_op    <= w_op_next;
            r_valid <= (w_state_next == S_RUN);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_a_next     = r_a;
        w_b_next     = r_b;
        w_op_next    = r_op;
`ifdef ALU_SEQ_LIVE_OP_EN
        if (r_state == S_RUN) begin
            w_op_next = sw_op;
        end
`endif
        if (w_press) begin
            case (r_state)
                S_LOAD_A: begin
                    w_a_next     = sw_data;
                    w_state_next = S_LOAD_B;
                end
                S_LOAD_B: begin
                    w_b_next     = sw_data;
                    w_state_next = S_LOAD_OP;
                end
                S_LOAD_OP: begin
                    w_op_next    = sw_op;
                    w_state_next = S_RUN;
                end
                default: begin
                    w_state_next = S_LOAD_A;
                end
            endcase
        end
    end

    assign A              = r_a;
    assign B              = r_b;
    assign OpCode         = r_op;
    assign operands_valid = r_valid;
    assign step           = r_state;
    assign press          = w_rise;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Scoreboard bench for alu_operand_sequencer with a short debounce window.
module tb_alu_operand_sequencer;

    localparam int DEB     = 4;
    localparam int LATENCY = 2 + DEB + 1;

`ifdef ALU_SEQ_LIVE_OP_EN
    localparam bit LIVE = 1'b1;
`else
    localparam bit LIVE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_next;
    logic [6:0] sw_data;
    logic [1:0] sw_op;
    logic [6:0] A;
    logic [6:0] B;
    logic [1:0] OpCode;
    logic       operands_valid;
    logic [1:0] step;
    logic       press;

    alu_operand_sequencer #(
        .WIDTH          (7),
        .OP_WIDTH       (2),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_next      (btn_next),
        .sw_data       (sw_data),
        .sw_op         (sw_op),
        .A             (A),
        .B             (B),
        .OpCode        (OpCode),
        .operands_valid(operands_valid),
        .step          (step),
        .press         (press)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int op;
        int stp;
        int valid;
        int rise_cyc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_rise = 0;

    // Reference model: which field the next press captures, as plain integers.
    int   m_step;
    int   m_a;
    int   m_b;
    int   m_op;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic btn_rise_now();
        btn_next  = 1'b1;
        last_rise = cyc;
    endtask

    task automatic model_press();
        exp_t e;
        case (m_step)
            0: m_a = int'(sw_data);
            1: m_b = int'(sw_data);
            2: m_op = int'(sw_op);
            default: if (LIVE) m_op = int'(sw_op);
        endcase
        m_step     = (m_step + 1) % 4;
        e.a        = m_a;
        e.b        = m_b;
        e.op       = m_op;
        e.stp      = m_step;
        e.valid    = (m_step == 3) ? 1 : 0;
        e.rise_cyc = 0;
        q.push_back(e);
    endtask

    task automatic model_reset();
        m_step = 0;
        m_a    = 0;
        m_b    = 0;
        m_op   = 0;
    endtask

    task automatic press_clean(input int hold);
        model_press();
        btn_rise_now();
        cycles(hold);
        btn_next = 1'b0;
        cycles(DEB + 8);
    endtask

    // Glitches of 1..3 cycles on both edges; only the final stable hold may count.
    task automatic press_bouncy(input int hold);
        model_press();
        for (int k = 0; k < 3; k++) begin
            btn_rise_now();
            cycles(int'($urandom_range(1, 3)));
            btn_next = 1'b0;
            cycles(int'($urandom_range(1, 3)));
        end
        btn_rise_now();
        cycles(hold);
        for (int k = 0; k < 3; k++) begin
            btn_next = 1'b0;
            cycles(int'($urandom_range(1, 3)));
            btn_next = 1'b1;
            cycles(int'($urandom_range(1, 3)));
        end
        btn_next = 1'b0;
        cycles(DEB + 8);
    endtask

    task automatic noise();
        for (int k = 0; k < 3; k++) begin
            sw_data = 7'($urandom);
            if (m_step != 3) sw_op = 2'($urandom);
            cycles(1);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".A"}, int'(A), m_a);
        chk({tag, ".B"}, int'(B), m_b);
        chk({tag, ".OpCode"}, int'(OpCode), m_op);
        chk({tag, ".step"}, int'(step), m_step);
        chk({tag, ".valid"}, int'(operands_valid), (m_step == 3) ? 1 : 0);
    endtask

    // Monitor: every press pulse must match a queued expectation; outputs are checked one edge later.
    always @(negedge clk) begin
        if (!reset && press) begin
            if (q.size() == 0) begin
                chk("unexpected_press", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("press_latency", cyc - last_rise, LATENCY);
                @(negedge clk);
                chk("mon.press_width", int'(press), 0);
                chk("mon.A", int'(A), e.a);
                chk("mon.B", int'(B), e.b);
                chk("mon.OpCode", int'(OpCode), e.op);
                chk("mon.step", int'(step), e.stp);
                chk("mon.valid", int'(operands_valid), e.valid);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        btn_next = 1'b0;
        sw_data  = '0;
        sw_op    = '0;
        model_reset();
        cycles(3);
        check_state("reset");
        reset = 1'b0;
        cycles(3);

        // Clean press in LOAD_A, then finish the first operand set.
        sw_data = 7'h12;
        press_clean(15);
        check_state("loadA");
        sw_data = 7'h05;
        press_clean(12);
        sw_op = 2'b01;
        press_clean(12);
        check_state("run1");

        // Switch changes in RUN: OpCode holds unless the live-op feature is built in.
        sw_op   = 2'b10;
        sw_data = 7'h7F;
        cycles(2);
        if (LIVE) m_op = 2;
        check_state("run_sweep");
        press_clean(12);

        // Full bouncy sequence, with a 100-cycle hold in LOAD_B.
        sw_data = 7'h0A;
        press_bouncy(20);
        sw_data = 7'h05;
        press_clean(100);
        check_state("held_loadB");
        sw_op = 2'b01;
        press_bouncy(20);
        check_state("run2");
        press_bouncy(20);
        check_state("wrap");

        // Async reset mid-RUN, then the next press latches A again.
        sw_data = 7'h55;
        press_clean(12);
        sw_data = 7'h33;
        press_clean(12);
        sw_op = 2'b11;
        press_clean(12);
        chk("pre_reset_A", int'(A), 7'h55);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_state("async_reset");
        cycles(2);
        reset = 1'b0;
        cycles(2);
        sw_data = 7'h21;
        press_clean(12);
        check_state("after_reset");

        // Randomised presses with switch noise between them.
        for (int i = 0; i < 12; i++) begin
            noise();
            sw_data = 7'($urandom);
            if (m_step != 3) sw_op = 2'($urandom);
            if ($urandom_range(0, 1) == 1) press_bouncy(int'($urandom_range(10, 30)));
            else press_clean(int'($urandom_range(10, 40)));
        end
        check_state("random_end");

        cycles(4);
        chk("pending_presses", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
